// File: rtl/simple_uart_transmitter.sv
// 8N1 UART transmitter, LSB first, fed from a small byte FIFO.
// Frames run back-to-back while the FIFO holds data.
module simple_uart_transmitter #(
  parameter int CLK_FREQ   = 250_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_dat,
  input  logic                          i_dat_vld,
  output logic                          o_dat_rdy,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tmr;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_wrap;
  logic [7:0]    w_rd_dat;

  assign w_full   = (r_cnt == CNT_FULL);
  assign w_empty  = (r_cnt == '0);
  assign w_push   = i_dat_vld & ~w_full;
  assign w_wrap   = (r_tmr == TMR_LAST);
  assign w_rd_dat = r_mem[r_rd_ptr];

  // Pop on the IDLE load or exactly on the STOP wrap (no idle gap).
  assign w_pop = ~w_empty &
                 ((r_state == S_IDLE) |
                  ((r_state == S_STOP) & w_wrap));

  assign o_dat_rdy  = ~w_full;
  assign o_tx       = r_tx;
  assign o_busy     = r_busy;
  assign o_fifo_cnt = r_cnt;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_tmr <= '0;
          r_tx  <= 1'b1;
          if (w_pop) begin
            r_shift <= w_rd_dat;
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_wrap) begin
            r_tmr   <= '0;
            r_idx   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_DATA: begin
          if (w_wrap) begin
            r_tmr <= '0;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_STOP: begin
          if (w_wrap) begin
            r_tmr <= '0;
            if (w_pop) begin
              r_shift <= w_rd_dat;
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_uart_transmitter.sv
// Bench for simple_uart_transmitter: frame vectors, corner sequences
// and random traffic against a queue-based line model.
module tb_simple_uart_transmitter;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 4;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    dat = 8'h00;
  logic          vld = 1'b0;
  logic          rdy;
  logic          tx;
  logic          busy;
  logic [CW-1:0] cnt;

  simple_uart_transmitter #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_dat     (dat),
    .i_dat_vld (vld),
    .o_dat_rdy (rdy),
    .o_tx      (tx),
    .o_busy    (busy),
    .o_fifo_cnt(cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Reference: a byte queue plus a position inside the current frame.
  logic [7:0] mq[$];
  logic       m_infr = 1'b0;
  int         m_pos  = 0;
  logic [7:0] m_cur  = 8'h00;
  logic       m_acc  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_infr = 1'b0;
      m_pos  = 0;
      m_acc  = 1'b0;
    end else begin
      m_acc = vld && (mq.size() < DEPTH);
      if (m_infr && m_pos < FRAME - 1) begin
        m_pos++;
      end else if (mq.size() > 0) begin
        m_cur  = mq.pop_front();
        m_infr = 1'b1;
        m_pos  = 0;
      end else begin
        m_infr = 1'b0;
      end
      if (m_acc) mq.push_back(dat);
    end
  end

  function automatic logic m_tx();
    int k;
    if (!m_infr) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  logic chk_on = 1'b0;

  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      chk("line_tx", 64'(tx), 64'(m_tx()));
      chk("line_busy", 64'(busy), 64'(m_infr));
      chk("line_cnt", 64'(cnt), 64'(mq.size()));
      chk("line_rdy", 64'(rdy), 64'(mq.size() != DEPTH));
    end
  end

  task automatic push(input logic [7:0] b, input bit keep);
    dat = b;
    vld = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_acc) begin
        if (!keep) vld = 1'b0;
        dat = 8'($urandom);
        return;
      end
    end
    timeout("push");
    vld = 1'b0;
  endtask

  task automatic run_frames(output logic [63:0] bits, output int blen);
    int t;
    bits = '0;
    blen = 0;
    for (int i = 0; i < 300; i++) begin
      if (tx === 1'b0) break;
      @(negedge clk);
    end
    if (tx !== 1'b0) begin
      timeout("frame_start");
      return;
    end
    t = 0;
    while (busy === 1'b1 && t < 1000) begin
      if (t % CPB == CPB / 2 && t / CPB < 64) bits[t/CPB] = tx;
      t++;
      @(negedge clk);
    end
    blen = t;
  endtask

  task automatic check_reset_outs(input string nm);
    chk({nm, "_tx"}, 64'(tx), 64'(1));
    chk({nm, "_busy"}, 64'(busy), 64'(0));
    chk({nm, "_rdy"}, 64'(rdy), 64'(1));
    chk({nm, "_cnt"}, 64'(cnt), 64'(0));
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && cnt == '0) return;
    end
    timeout(nm);
  endtask

  typedef struct {
    logic [7:0] dat;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] bits;
    int          blen;
    logic        rdy_low;
    int          maxcnt;
    int          quiet;
    int          rst_at;
    int          pct;
    logic [9:0]  ef;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'hFF, 10'b1111111110};
    vecs[2] = '{8'h00, 10'b1000000000};
    vecs[3] = '{8'h01, 10'b1000000010};
    vecs[4] = '{8'h80, 10'b1100000000};
    vecs[5] = '{8'h3C, 10'b1001111000};

    repeat (3) @(negedge clk);
    #1;
    check_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;

    // Single frames with push-to-line latency.
    for (int v = 0; v < 6; v++) begin
      push(vecs[v].dat, 1'b0);
      chk("lat_pre_tx", 64'(tx), 64'(1));
      @(negedge clk);
      chk("lat_post_tx", 64'(tx), 64'(0));
      chk("lat_post_busy", 64'(busy), 64'(1));
      run_frames(bits, blen);
      chk("vec_frame", 64'(bits[9:0]), 64'(vecs[v].frame));
      chk("vec_busy_len", 64'(blen), 64'(FRAME));
    end

    // 0xFF then 0x00 back-to-back.
    fork
      begin
        push(8'hFF, 1'b1);
        push(8'h00, 1'b0);
      end
      run_frames(bits, blen);
    join
    chk("b2b_bits", 64'(bits[19:0]), 64'(20'b1000000000_1111111110));
    chk("b2b_len", 64'(blen), 64'(2 * FRAME));

    // Six bytes with vld held: FIFO fills, then drains continuously.
    rdy_low = 1'b0;
    maxcnt  = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) push(8'(i), i != 5);
      end
      run_frames(bits, blen);
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (vld && !rdy) rdy_low = 1'b1;
          if (int'(cnt) > maxcnt) maxcnt = int'(cnt);
        end
      end
    join
    chk("burst_rdy_low", 64'(rdy_low), 64'(1));
    chk("burst_maxcnt", 64'(maxcnt), 64'(DEPTH));
    chk("burst_len", 64'(blen), 64'(6 * FRAME));
    for (int f = 0; f < 6; f++) begin
      ef = {1'b1, 8'(f), 1'b0};
      chk("burst_frame", 64'(bits[f*10 +: 10]), 64'(ef));
    end
    chk("burst_cnt_end", 64'(cnt), 64'(0));

    // Full FIFO: push during the STOP pop cycle is refused, retry lands.
    push(8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) push(8'($urandom), 1'b1);
    dat = 8'hC3;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 150; i++) begin
      if (tx === 1'b0) break;
      @(negedge clk);
    end
    if (tx !== 1'b0) timeout("full_pop");
    chk("full_pop_cnt", 64'(cnt), 64'(DEPTH - 1));
    chk("full_pop_rdy", 64'(rdy), 64'(1));
    @(negedge clk);
    chk("full_retry_cnt", 64'(cnt), 64'(DEPTH));
    vld = 1'b0;
    wait_idle("full_drain");

    // Reset in the middle of DATA bit 3 of the first frame.
    push(8'h00, 1'b1);
    push(8'($urandom), 1'b1);
    push(8'($urandom), 1'b0);
    repeat (43) @(negedge clk);
    chk("pre_rst_tx", 64'(tx), 64'(0));
    chk("pre_rst_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check_reset_outs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    quiet = 0;
    repeat (250) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) quiet++;
    end
    chk("post_rst_quiet", 64'(quiet), 64'(0));
    push(8'h5A, 1'b0);
    run_frames(bits, blen);
    chk("post_rst_frame", 64'(bits[9:0]), 64'(10'b1010110100));

    // Random traffic with one asynchronous reset at a random time.
    rst_at = int'($urandom_range(500, 2000));
    pct    = 80;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 200 == 0) pct = int'($urandom_range(0, 100));
      if (c == rst_at) begin
        #3;
        rst = 1'b1;
        #1;
        check_reset_outs("rnd_rst");
        repeat (int'($urandom_range(1, 3))) begin
          @(negedge clk);
          vld = 1'($urandom);
          dat = 8'($urandom);
          #1;
          check_reset_outs("rnd_rst_hold");
        end
        rst = 1'b0;
      end else begin
        vld = (int'($urandom_range(0, 99)) < pct);
        dat = 8'($urandom);
      end
    end
    vld = 1'b0;
    wait_idle("rnd_drain");
    @(negedge clk);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
